// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential Booth multiplier.
package mult_pkg;

    localparam int WIDTH = 32;                 // operand width, multiple of 4
    localparam int STEPS = WIDTH / 4;          // 4 multiplier bits retired per cycle
    localparam int ACC_W = WIDTH + 4;          // accumulator: room for |d| <= 8 times mcand
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/booth4_step.sv
// Combinational 4-bit Booth step: p = d * mcand, where d is the sum of four
// radix-2 Booth digits taken from the 5-bit window {y[3:0], y_prev}.
module booth4_step
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] mcand,
    input  logic [4:0]       window,
    output logic [ACC_W-1:0] p
);

    logic [ACC_W-1:0] m_ext;

    // Sum the per-bit digits (window[i] - window[i+1]) * 2^i * mcand.
    always_comb begin
        m_ext = {{(ACC_W - WIDTH){mcand[WIDTH-1]}}, mcand};
        p     = '0;
        for (int i = 0; i < 4; i++) begin
            if (window[i] && !window[i+1]) begin
                p = p + (m_ext << i);
            end else if (!window[i] && window[i+1]) begin
                p = p - (m_ext << i);
            end
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, 4 bits per cycle.
//
// Handshake: start is sampled only in IDLE or DONE; the edge that samples it
// captures a/b and enters RUN (busy=1). start during RUN is ignored. After
// STEPS step edges the FSM is in DONE with done=1 and product updated for
// exactly that cycle; holding start in DONE launches the next multiply.
module booth_mult_seq
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output mult_state_e          dbg_state
);

    mult_state_e             state_q, state_d;
    logic [WIDTH-1:0]        mcand_q, mcand_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]        lo_q, lo_d;
    logic                    yprev_q, yprev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      product_q, product_d;

    logic [ACC_W-1:0]        p;
    logic signed [ACC_W-1:0] s;

    booth4_step u_step (
        .mcand  (mcand_q),
        .window ({lo_q[3:0], yprev_q}),
        .p      (p)
    );

    assign s = acc_q + p;

    // State and datapath registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            yprev_q   <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            yprev_q   <= yprev_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update: load on accepted start, step in RUN.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        yprev_d   = yprev_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    mcand_d = a;
                    lo_d    = b;
                    acc_d   = '0;
                    yprev_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = s >>> 4;
                lo_d    = {s[3:0], lo_q[WIDTH-1:4]};
                yprev_d = lo_q[3];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d   = DONE;
                    // Post-shift {acc[WIDTH-1:0], lo}: the full sum s lands
                    // directly above the 28 surviving low bits.
                    product_d = {s, lo_q[WIDTH-1:4]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed cases, handshake, async reset, random.
module tb_booth_mult_seq;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    mult_state_e dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    booth_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact signed 64-bit product by plain arithmetic
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply: present operands with start, then wait (bounded) for done.
    task automatic do_mult(input logic [31:0] av, input logic [31:0] bv,
                           input bit hold, input string tag);
        logic [63:0] prev_prod;
        int lat;
        int busy_cycles;
        int changes;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        a = $urandom;
        b = $urandom;
        prev_prod = product;
        lat = 0;
        busy_cycles = 0;
        changes = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            if (product !== prev_prod) changes++;
            tick();
            lat++;
        end
        last_done_cyc = cyc;
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd8);
        check({tag, " product_stable"}, 64'(changes), 64'd0);
        check({tag, " product"}, product, ref_mul(av, bv));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t1;
        int n_done;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", product, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle busy", 64'(busy), 64'd0);

        // Basic and single done pulse
        do_mult(32'd3, 32'd5, 1'b0, "basic");
        check("basic abs", product, 64'h0000_0000_0000_000F);
        tick();
        check("basic done_drop", 64'(done), 64'd0);
        check("basic idle_busy", 64'(busy), 64'd0);
        check("basic held", product, 64'h0000_0000_0000_000F);

        // Signs and extremes
        do_mult(-32'sd7, 32'd6, 1'b0, "neg7x6");
        check("neg7x6 abs", product, 64'hFFFF_FFFF_FFFF_FFD6);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "m1xm1");
        check("m1xm1 abs", product, 64'h0000_0000_0000_0001);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, "minxmin");
        check("minxmin abs", product, 64'h4000_0000_0000_0000);
        do_mult(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "maxxmin");
        check("maxxmin abs", product, 64'hC000_0000_8000_0000);

        // start during RUN is ignored
        a = 32'd1000; b = 32'd77; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 32'd12345; b = 32'd999; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        while (done !== 1'b1 && n_done < 20) begin
            tick();
            n_done++;
        end
        check("ignore product", product, 64'd77000);
        tick();
        check("ignore no_requeue busy", 64'(busy), 64'd0);
        check("ignore no_requeue done", 64'(done), 64'd0);

        // start held in DONE: back-to-back, done pulses 9 cycles apart
        do_mult(32'd123456, 32'hFFFF_0000, 1'b1, "hold1");
        t1 = last_done_cyc;
        do_mult(32'h0BAD_F00D, 32'd31, 1'b1, "hold2");
        check("hold spacing", 64'(last_done_cyc - t1), 64'd9);
        start = 1'b0;
        tick();

        // Asynchronous reset mid-RUN
        a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("midrst busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst product", product, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        check("midrst no_activity", 64'(n_done), 64'd0);
        do_mult(32'd2, 32'd2, 1'b0, "post_rst");
        check("post_rst abs", product, 64'd4);

        // Random back-to-back multiplies
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) ra = 32'h8000_0000;
            if (i % 70 == 1) rb = 32'h7FFF_FFFF;
            t1 = last_done_cyc;
            do_mult(ra, rb, 1'b1, "rand");
            if (i > 0) check("rand spacing", 64'(last_done_cyc - t1), 64'd9);
        end
        start = 1'b0;
        tick();
        tick();
        check("final idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
